// File: rtl/mb_pkg.sv
// rtl/mb_pkg.sv - shared constants and types for the mainband receive path
package mb_pkg;

    // Valid lane per 8-UI group, UI0 in the LSB: high for UI0..3, low for UI4..7.
    localparam logic [7:0] VALID_PATTERN = 8'b0000_1111;
    localparam int         UI_PER_GROUP  = 8;

    typedef enum logic {
        IDLE = 1'b0,
        RECV = 1'b1
    } rx_state_e;

endpackage

// File: rtl/mb_flit_fifo.sv
// rtl/mb_flit_fifo.sv - single-clock flit FIFO with wrap-bit pointers and fill count
module mb_flit_fifo #(
    parameter int WIDTH = 512,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   fill
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_pop;

    assign fill   = wr_ptr - rd_ptr;
    assign full   = (fill == (AW+1)'(DEPTH));
    assign empty  = (fill == '0);
    assign do_pop = pop && !empty;

    // Head reads as zero when empty so the output is clean out of reset.
    assign head_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/mb_rx_deser.sv
// rtl/mb_rx_deser.sv - mainband receive deserialiser: valid framing, flit assembly, flit FIFO
module mb_rx_deser
    import mb_pkg::*;
#(
    parameter int NUM_LANES  = 16,
    parameter int FLIT_BYTES = 64,
    parameter int FLIT_DEPTH = 2
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          valid_i,
    input  logic [NUM_LANES-1:0]          data_i,
    input  logic                          lane_rev_i,
    output logic                          flit_valid_o,
    input  logic                          flit_ready_i,
    output logic [FLIT_BYTES*8-1:0]       flit_data_o,
    output logic                          frame_err_o,
    output logic                          overflow_o,
    output logic [$clog2(FLIT_DEPTH):0]   fill_o
);

    localparam int G  = FLIT_BYTES / NUM_LANES;
    localparam int GW = (G > 1) ? $clog2(G) : 1;
    localparam int LW = $clog2(NUM_LANES);
    localparam int FW = FLIT_BYTES * 8;

    rx_state_e                       state_q, state_d;
    logic [2:0]                      ui_q, ui_d;
    logic [GW-1:0]                   grp_q, grp_d;
    logic                            rev_q, rev_d;
    logic                            err_q, err_d;
    logic                            cmpl_q, cmpl_d;
    logic                            store_en;
    logic                            eff_rev;
    logic [NUM_LANES-1:0]            data_rev;
    logic [NUM_LANES-1:0]            lane_data;
    logic [G-1:0][NUM_LANES-1:0][7:0] asm_q;
    logic                            push;
    logic                            pop;
    logic                            full;
    logic                            empty;

    // The first UI of a flit must already use the new reversal setting.
    assign data_rev  = {<<{data_i}};
    assign eff_rev   = (state_q == IDLE && grp_q == '0) ? lane_rev_i : rev_q;
    assign lane_data = eff_rev ? data_rev : data_i;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            ui_q    <= '0;
            grp_q   <= '0;
            rev_q   <= 1'b0;
            err_q   <= 1'b0;
            cmpl_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ui_q    <= ui_d;
            grp_q   <= grp_d;
            rev_q   <= rev_d;
            err_q   <= err_d;
            cmpl_q  <= cmpl_d;
        end
    end

    always_ff @(posedge clk) begin
        if (store_en) begin
            for (int b = 0; b < NUM_LANES; b++) begin
                asm_q[grp_q][b[LW-1:0]][ui_q] <= lane_data[b[LW-1:0]];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        ui_d     = ui_q;
        grp_d    = grp_q;
        rev_d    = rev_q;
        err_d    = 1'b0;
        cmpl_d   = 1'b0;
        store_en = 1'b0;
        case (state_q)
            IDLE: begin
                if (valid_i) begin
                    store_en = 1'b1;
                    ui_d     = 3'd1;
                    state_d  = RECV;
                    if (grp_q == '0) begin
                        rev_d = lane_rev_i;
                    end
                end
            end
            RECV: begin
                if (valid_i == VALID_PATTERN[ui_q]) begin
                    store_en = 1'b1;
                    ui_d     = ui_q + 3'd1;
                    if (ui_q == 3'(UI_PER_GROUP - 1)) begin
                        ui_d    = '0;
                        state_d = IDLE;
                        if (grp_q == GW'(G - 1)) begin
                            grp_d  = '0;
                            cmpl_d = 1'b1;
                        end else begin
                            grp_d = grp_q + GW'(1);
                        end
                    end
                end else begin
                    // Erroring UI is consumed here; it never restarts a group.
                    err_d   = 1'b1;
                    grp_d   = '0;
                    ui_d    = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        flit_valid_o = !empty;
        pop          = !empty && flit_ready_i;
        push         = cmpl_q && (!full || pop);
        overflow_o   = cmpl_q && full && !pop;
        frame_err_o  = err_q;
    end

    mb_flit_fifo #(
        .WIDTH (FW),
        .DEPTH (FLIT_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (push),
        .push_data (asm_q),
        .pop       (pop),
        .head_data (flit_data_o),
        .full      (full),
        .empty     (empty),
        .fill      (fill_o)
    );

endmodule
